// File: rtl/day05_pkg.sv
// day05_pkg: shared state encoding, ASCII constants and token kinds for the day-05 parser.
package day05_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;
    localparam int DEF_VAL_W = 64;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_DASH = 8'h2d;
    localparam logic [7:0] CH_LF   = 8'h0a;
    localparam logic [7:0] CH_CR   = 8'h0d;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_NUL  = 8'h00;
    localparam logic KIND_RANGE = 1'b0;
    localparam logic KIND_VALUE = 1'b1;
endpackage

// File: rtl/day05_parser_if.sv
// day05_parser_if: control, ROM and token-stream bundle of the day-05 parser.
//   master = parser side (drives rom_addr, token stream, counters, flags)
//   slave  = environment side (drives start, ROM response, out_ready)
interface day05_parser_if
    import day05_pkg::*;
#(
    parameter int N_ADDR_BITS = 16,
    parameter int VAL_W       = DEF_VAL_W
);
    logic                 start;
    logic [N_ADDR_BITS:0] rom_addr;
    logic [7:0]           rom_data;
    logic                 rom_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_kind;
    logic [VAL_W-1:0]     out_lo;
    logic [VAL_W-1:0]     out_hi;
    logic [15:0]          n_ranges;
    logic [15:0]          n_values;
    logic                 parse_err;
    logic                 done;

    modport master (
        input  start, rom_data, rom_valid, out_ready,
        output rom_addr, out_valid, out_kind, out_lo, out_hi, n_ranges, n_values, parse_err, done
    );
    modport slave (
        output start, rom_data, rom_valid, out_ready,
        input  rom_addr, out_valid, out_kind, out_lo, out_hi, n_ranges, n_values, parse_err, done
    );
endinterface

// File: rtl/day05_parser_dec_accum.sv
// dec_accum: one decimal digit step, acc*10 + d as shifts and adds, wrapping at VAL_W bits.
//   i_acc   current accumulator
//   i_digit incoming digit 0-9
//   o_next  updated accumulator
module dec_accum #(
    parameter int VAL_W = 64
) (
    input  logic [VAL_W-1:0] i_acc,
    input  logic [3:0]       i_digit,
    output logic [VAL_W-1:0] o_next
);
    assign o_next = (i_acc << 3) + (i_acc << 1) + VAL_W'(i_digit);
endmodule

// File: rtl/day05_parser.sv
// day05_parser: walks the puzzle ROM and turns ASCII range/ID lines into binary tokens.
//   clk, rst  clock and asynchronous active-high reset
//   bus       start pulse, ROM request/response, token stream, counters, parse_err, done
module day05_parser
    import day05_pkg::*;
#(
    parameter int N_ADDR_BITS = 16,
    parameter int VAL_W       = DEF_VAL_W
) (
    input logic            clk,
    input logic            rst,
    day05_parser_if.master bus
);
    state_t               r_state, w_state;
    logic [N_ADDR_BITS:0] r_addr, w_addr;
    logic [VAL_W-1:0]     r_acc, w_acc, r_lo, w_lo, r_olo, w_olo, r_ohi, w_ohi, w_acc_dec;
    logic                 r_hd, w_hd, r_hdash, w_hdash, r_sec, w_sec, r_eof, w_eof;
    logic                 r_ov, w_ov, r_kind, w_kind, r_err, w_err, r_done, w_done;
    logic [15:0]          r_nr, w_nr, r_nv, w_nv;
    logic                 w_is_digit, w_end, w_eol;

    // low nibble of an ASCII digit is its value
    dec_accum #(.VAL_W(VAL_W)) u_acc (.i_acc(r_acc), .i_digit(bus.rom_data[3:0]), .o_next(w_acc_dec));

    assign w_is_digit = bus.rom_data >= CH_0 && bus.rom_data <= CH_9;
    // the all-ones address is the last byte the ROM can ever return
    assign w_end      = !bus.rom_valid || (&r_addr);
    assign w_eol      = bus.rom_valid && bus.rom_data == CH_LF;

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_acc   = r_acc;
        w_lo    = r_lo;
        w_hd    = r_hd;
        w_hdash = r_hdash;
        w_sec   = r_sec;
        w_eof   = r_eof;
        w_ov    = r_ov;
        w_kind  = r_kind;
        w_olo   = r_olo;
        w_ohi   = r_ohi;
        w_nr    = r_nr;
        w_nv    = r_nv;
        w_err   = r_err;
        w_done  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_done = r_state == S_DONE;
                if (bus.start) begin
                    w_state = S_FETCH;
                    w_addr  = '0;
                    w_acc   = '0;
                    w_lo    = '0;
                    w_hd    = 1'b0;
                    w_hdash = 1'b0;
                    w_sec   = KIND_RANGE;
                    w_eof   = 1'b0;
                    w_nr    = '0;
                    w_nv    = '0;
                    w_err   = 1'b0;
                    w_done  = 1'b0;
                end
            end
            S_FETCH: w_state = S_WAIT;
            S_WAIT: begin
                if (bus.rom_valid) begin
                    if (w_is_digit) begin
                        w_acc = w_acc_dec;
                        w_hd  = 1'b1;
                    end else if (bus.rom_data == CH_DASH) begin
                        if (r_sec == KIND_RANGE && !r_hdash) begin
                            w_lo    = r_acc;
                            w_acc   = '0;
                            w_hdash = 1'b1;
                        end else
                            w_err = 1'b1;
                    end else if (bus.rom_data == CH_LF) begin
                        if (!r_hd && !r_hdash && r_sec == KIND_RANGE)
                            w_sec = KIND_VALUE;
                    end else if (!(bus.rom_data == CH_CR || bus.rom_data == CH_NUL || bus.rom_data == CH_SP))
                        w_err = 1'b1;
                end
                // token built from the post-byte state so a digit at the last address still lands
                if (w_hd && (w_eol || w_end)) begin
                    w_state = S_EMIT;
                    w_ov    = 1'b1;
                    w_kind  = w_sec;
                    w_olo   = (w_sec == KIND_RANGE && w_hdash) ? w_lo : w_acc;
                    w_ohi   = w_sec == KIND_RANGE ? w_acc : '0;
                    w_eof   = w_end;
                    if (w_sec == KIND_RANGE && !w_hdash)
                        w_err = 1'b1;
                end else if (w_end)
                    w_state = S_DONE;
                else begin
                    w_state = S_FETCH;
                    w_addr  = r_addr + 1'b1;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    w_ov    = 1'b0;
                    w_acc   = '0;
                    w_lo    = '0;
                    w_hd    = 1'b0;
                    w_hdash = 1'b0;
                    w_nr    = r_kind == KIND_RANGE ? r_nr + 16'(r_nr != 16'hffff) : r_nr;
                    w_nv    = r_kind == KIND_VALUE ? r_nv + 16'(r_nv != 16'hffff) : r_nv;
                    w_addr  = r_addr + 1'b1;
                    w_state = r_eof ? S_DONE : S_FETCH;
                    w_done  = r_eof;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_hd    <= 1'b0;
            r_hdash <= 1'b0;
            r_sec   <= KIND_RANGE;
            r_eof   <= 1'b0;
            r_ov    <= 1'b0;
            r_kind  <= 1'b0;
            r_olo   <= '0;
            r_ohi   <= '0;
            r_nr    <= '0;
            r_nv    <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_acc   <= w_acc;
            r_lo    <= w_lo;
            r_hd    <= w_hd;
            r_hdash <= w_hdash;
            r_sec   <= w_sec;
            r_eof   <= w_eof;
            r_ov    <= w_ov;
            r_kind  <= w_kind;
            r_olo   <= w_olo;
            r_ohi   <= w_ohi;
            r_nr    <= w_nr;
            r_nv    <= w_nv;
            r_err   <= w_err;
            r_done  <= w_done;
        end
    end

    assign bus.rom_addr  = r_addr;
    assign bus.out_valid = r_ov;
    assign bus.out_kind  = r_kind;
    assign bus.out_lo    = r_olo;
    assign bus.out_hi    = r_ohi;
    assign bus.n_ranges  = r_nr;
    assign bus.n_values  = r_nv;
    assign bus.parse_err = r_err;
    assign bus.done      = r_done;
endmodule

// File: doc/day05_parser.md
# day05_parser

Upstream front end of the day-05 solver. Walks the puzzle-input ROM byte by byte and parses the ASCII text into binary tokens for the day-05 core:

- one range token `(lo, hi)` per `a-b` line;
- one value token per ID line after the blank separator line.

Tokens leave on a valid/ready stream, so the core's sort/merge/search logic consumes pre-parsed 64-bit numbers and never touches ASCII.

## Interface
Parameters:
- `N_ADDR_BITS`, 16, ROM address width minus one (`rom_addr` is `N_ADDR_BITS+1` bits).
- `VAL_W`, 64, token number width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins parsing from address 0; ignored unless idle or done.
- `rom_addr`  out  N_ADDR_BITS+1  registered byte address.
- `rom_data`  in  8  byte returned for the address issued the previous cycle.
- `rom_valid`  in  1  qualifies `rom_data`; low on the response cycle means end of file.
- `out_valid`  out  1  token available.
- `out_ready`  in  1  consumer accepts the token when `out_valid && out_ready`.
- `out_kind`  out  1  0 = range, 1 = value.
- `out_lo`  out  VAL_W  range low bound, or the value.
- `out_hi`  out  VAL_W  range high bound; 0 for value tokens.
- `n_ranges`  out  16  range tokens accepted so far.
- `n_values`  out  16  value tokens accepted so far.
- `parse_err`  out  1  sticky malformed-input flag.
- `done`  out  1  level; end of file reached and last token accepted.

## Operation
- **States:** `IDLE`, `FETCH`, `WAIT`, `EMIT`, `DONE`.
- **IDLE:**
  - On `start`, clear the accumulators, section flag, counters, `parse_err` and `done`.
  - Set `rom_addr` = 0 and go to `FETCH`.
- **FETCH:** drive `rom_addr`, go to `WAIT`.
- **WAIT:** sample `rom_data` / `rom_valid`, then classify.
  - **Digit `0`–`9`:** `acc <= acc*10 + d`, modulo 2^VAL_W (wrap silently). Set `have_digit`.
  - **`-` in the range section:**
    - First `-` on the line: move `acc` to `lo`, clear `acc`, set `have_dash`.
    - Second `-`, or `-` in the value section: set `parse_err` and ignore the byte.
  - **`\n`, range section, `have_digit`:** emit a range token with `lo`, `hi = acc`.
    - If `have_dash` is clear, emit `lo = hi = acc` and set `parse_err`.
  - **`\n`, range section, no digits and no dash:** switch to the value section. Extra blank lines in the value section are ignored.
  - **`\n`, value section, `have_digit`:** emit a value token, `lo = acc`.
  - **`\r`, `0x00`, space:** ignored.
  - **Any other byte:** set `parse_err`, ignore.
  - **After a non-emitting byte:** increment `rom_addr`, go to `FETCH`.
- **`rom_valid` low (EOF):**
  - If `have_digit`, emit the pending token exactly as a `\n` would have.
  - Then go to `DONE`.
- **Address wrap:** a `rom_valid` high response at the all-ones address is processed normally, then treated as EOF.
- **EMIT:**
  - Hold `out_valid` and the payload stable until `out_ready`.
  - On the handshake: clear `acc`, `lo`, `have_digit`, `have_dash`; bump the matching counter; advance `rom_addr`.
  - Go to `FETCH`, or to `DONE` if EOF is pending.
- **DONE:** `done` = 1. Hold all outputs until reset or `start`.
- **Range order:** `lo > hi` is passed through unchanged; the consumer owns that case.
- **Counter width:** counters saturate at 0xFFFF.

## Timing
- **Reset values:** all outputs 0 (`rom_addr`, `out_*`, counters, `parse_err`, `done`). State = `IDLE`.
- **Throughput:** exactly 2 cycles per non-emitting byte (`FETCH` + `WAIT`).
- **Emitting byte:** `out_valid` rises the cycle after `WAIT`. Minimum 3 cycles per emitting byte with `out_ready` held high.
- **Outputs:** registered. `out_valid` never drops without a handshake, except on reset.
- **Payload:** `out_kind`, `out_lo`, `out_hi` are unchanged while `out_valid && !out_ready`.
- **Counter update:** visible the cycle after the handshake.
- **`done`:** rises the cycle after the last handshake, or 2 cycles after the EOF response if nothing is pending.
- **`start` while busy:** ignored.
- **Reset mid-token:** the token is dropped, `out_valid` falls immediately (async), and no partial state survives.

## Structure
- **Shared package `day05_pkg`:**
  - state encoding;
  - ASCII constants (`CH_0`, `CH_9`, `CH_DASH`, `CH_LF`, `CH_CR`);
  - `KIND_RANGE` / `KIND_VALUE`;
  - `VAL_W` default.
- **Sub-module `dec_accum`:**
  - combinational `acc*10 + d`, computed as `(acc<<3) + (acc<<1) + d`;
  - truncated to `VAL_W`;
  - instantiated once, shared by the `lo` and `hi` phases.

## Test plan
- **Basic file:** ROM `3-5\n10-14\n\n5\n17\n`, `out_ready` = 1 → tokens R(3,5), R(10,14), V(5), V(17). Then `n_ranges` = 2, `n_values` = 2, `done` = 1, `parse_err` = 0.
- **Backpressure:** same file with `out_ready` toggling 1-in-3 → identical token sequence; payload stable while stalled; no token lost or duplicated.
- **CRLF and missing final newline:** `1-2\r\n\r\n9` → R(1,2), V(9) at EOF; `done` = 1; `parse_err` = 0.
- **Overflow and wrap:** `18446744073709551616-18446744073709551615\n` → R(0, 0xFFFF_FFFF_FFFF_FFFF).
- **Malformed input:**
  - `7\n\n4-2\n` → R(7,7), V(42), `parse_err` = 1.
  - `x` anywhere → `parse_err` = 1, remaining tokens unaffected.
- **Reset mid-operation:**
  - Assert `rst` while in `EMIT` with `out_ready` = 0 → `out_valid` = 0 and counters = 0 immediately.
  - A new `start` reparses from address 0 and reproduces the full token sequence.
